// File: rtl/icache_controller.sv
// Read-only instruction-cache controller: serves fetches from the cache array on
// a hit and, on a miss, fetches the whole block from instruction memory, refills
// the array and delivers the requested word. Keeps saturating hit/miss counters.
module icache_controller #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WORD_BITS   = 32,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned CNT_WIDTH   = 32,
  localparam int unsigned OFF        = $clog2(BLOCK_WORDS),
  localparam int unsigned BA_WIDTH   = ADDR_WIDTH - 2 - OFF,
  localparam int unsigned BLOCK_BITS = WORD_BITS * BLOCK_WORDS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  ren,
  input  logic [ADDR_WIDTH-1:0] pc,
  output logic                  stall,
  output logic [WORD_BITS-1:0]  instr,
  output logic                  cacheRen,
  output logic                  cacheMemWen,
  output logic [BA_WIDTH-1:0]   cacheBlockAddr,
  output logic [BLOCK_BITS-1:0] cacheDin,
  input  logic                  cacheHit,
  input  logic [BLOCK_BITS-1:0] cacheDout,
  output logic                  memRen,
  output logic [BA_WIDTH-1:0]   memBlockAddr,
  input  logic                  memReady,
  input  logic [BLOCK_BITS-1:0] memDout,
  output logic [CNT_WIDTH-1:0]  hitCount,
  output logic [CNT_WIDTH-1:0]  missCount
);

  typedef enum logic [1:0] {IDLE, MEM_REQ, REFILL} state_e;

  state_e                state_q, state_d;
  logic [BA_WIDTH-1:0]   ba_q, ba_d;
  logic [OFF-1:0]        off_q, off_d;
  logic [BLOCK_BITS-1:0] buf_q, buf_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;

  logic [BA_WIDTH-1:0]   pc_ba;
  logic [OFF-1:0]        pc_off;
  logic                  unused_pc;

  // Fetches are word-aligned, so the byte-offset bits of pc carry no information.
  assign pc_ba     = pc[ADDR_WIDTH-1:2+OFF];
  assign pc_off    = pc[2+OFF-1:2];
  assign unused_pc = ^pc[1:0];

  assign hitCount  = hit_q;
  assign missCount = miss_q;

  // Select one instruction word out of a block (word 0 in the low bits).
  function automatic logic [WORD_BITS-1:0] sel_word(input logic [BLOCK_BITS-1:0] blk,
                                                    input logic [OFF-1:0]        idx);
    sel_word = '0;
    for (int i = 0; i < int'(BLOCK_WORDS); i++) begin
      if (idx == OFF'(i)) sel_word = blk[i*WORD_BITS +: WORD_BITS];
    end
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    sat_inc = (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // State, latched miss info, block buffer and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ba_q    <= '0;
      off_q   <= '0;
      buf_q   <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      ba_q    <= ba_d;
      off_q   <= off_d;
      buf_q   <= buf_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  // Next-state and outputs; outputs are forced quiet while reset is asserted so
  // an abandoned memory request drops immediately.
  always_comb begin
    state_d        = state_q;
    ba_d           = ba_q;
    off_d          = off_q;
    buf_d          = buf_q;
    hit_d          = hit_q;
    miss_d         = miss_q;
    stall          = 1'b0;
    instr          = '0;
    cacheRen       = 1'b0;
    cacheMemWen    = 1'b0;
    cacheBlockAddr = '0;
    cacheDin       = '0;
    memRen         = 1'b0;
    memBlockAddr   = '0;
    if (reset) begin
      unique case (state_q)
        IDLE: begin
          cacheRen       = ren;
          cacheBlockAddr = pc_ba;
          if (ren && cacheHit) begin
            instr = sel_word(cacheDout, pc_off);
            hit_d = sat_inc(hit_q);
          end else if (ren) begin
            stall   = 1'b1;
            ba_d    = pc_ba;
            off_d   = pc_off;
            miss_d  = sat_inc(miss_q);
            state_d = MEM_REQ;
          end
        end
        MEM_REQ: begin
          stall        = 1'b1;
          memRen       = 1'b1;
          memBlockAddr = ba_q;
          if (memReady) begin
            buf_d   = memDout;
            state_d = REFILL;
          end
        end
        REFILL: begin
          cacheMemWen    = 1'b1;
          cacheBlockAddr = ba_q;
          cacheDin       = buf_q;
          instr          = sel_word(buf_q, off_q);
          state_d        = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
